// File: rtl/fifo_glb_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_glb_arbiter_if
// Bundles the lane-side request/address/data matrices and the single-port
// GLB bus that fifo_glb_arbiter sits between.
//   slave  : the arbiter (consumes lane requests, drives GLB and permits)
//   master : the lanes/GLB side (drives requests, receives permits/data)
// Matrices are flattened; lane i occupies bits [i*W +: W].
// ---------------------------------------------------------------------------
interface fifo_glb_arbiter_if #(
    parameter int NUM_LANE = 32,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [NUM_LANE-1:0]        ifmap_read_req_matrix_i;
    logic [NUM_LANE*ADDR_W-1:0] ifmap_glb_read_addr_matrix_i;
    logic [NUM_LANE-1:0]        ipsum_read_req_matrix_i;
    logic [NUM_LANE*ADDR_W-1:0] ipsum_glb_read_addr_matrix_i;
    logic [NUM_LANE-1:0]        opsum_glb_write_req_matrix_i;
    logic [NUM_LANE*ADDR_W-1:0] opsum_glb_write_addr_matrix_i;
    logic [NUM_LANE*4-1:0]      opsum_glb_write_web_matrix_i;
    logic [NUM_LANE*DATA_W-1:0] opsum_fifo_head_data_matrix_i;
    logic [DATA_W-1:0]          glb_read_data_i;

    logic                       glb_en_o;
    logic [ADDR_W-1:0]          glb_addr_o;
    logic [3:0]                 glb_web_o;
    logic [DATA_W-1:0]          glb_wdata_o;
    logic [NUM_LANE-1:0]        ifmap_permit_push_matrix_o;
    logic [NUM_LANE-1:0]        ipsum_permit_push_matrix_o;
    logic [NUM_LANE-1:0]        opsum_permit_pop_matrix_o;
    logic [DATA_W-1:0]          ifmap_glb_read_data_o;
    logic [DATA_W-1:0]          ipsum_glb_read_data_o;
    logic                       fifo_glb_busy_o;

    modport slave (
        input  ifmap_read_req_matrix_i, ifmap_glb_read_addr_matrix_i,
        input  ipsum_read_req_matrix_i, ipsum_glb_read_addr_matrix_i,
        input  opsum_glb_write_req_matrix_i, opsum_glb_write_addr_matrix_i,
        input  opsum_glb_write_web_matrix_i, opsum_fifo_head_data_matrix_i,
        input  glb_read_data_i,
        output glb_en_o, glb_addr_o, glb_web_o, glb_wdata_o,
        output ifmap_permit_push_matrix_o, ipsum_permit_push_matrix_o,
        output opsum_permit_pop_matrix_o,
        output ifmap_glb_read_data_o, ipsum_glb_read_data_o,
        output fifo_glb_busy_o
    );

    modport master (
        output ifmap_read_req_matrix_i, ifmap_glb_read_addr_matrix_i,
        output ipsum_read_req_matrix_i, ipsum_glb_read_addr_matrix_i,
        output opsum_glb_write_req_matrix_i, opsum_glb_write_addr_matrix_i,
        output opsum_glb_write_web_matrix_i, opsum_fifo_head_data_matrix_i,
        output glb_read_data_i,
        input  glb_en_o, glb_addr_o, glb_web_o, glb_wdata_o,
        input  ifmap_permit_push_matrix_o, ipsum_permit_push_matrix_o,
        input  opsum_permit_pop_matrix_o,
        input  ifmap_glb_read_data_o, ipsum_glb_read_data_o,
        input  fifo_glb_busy_o
    );
endinterface

// File: rtl/fifo_glb_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_glb_arbiter
// Shares the single-port GLB between NUM_LANE ifmap (read), ipsum (read) and
// opsum (write) FIFO controller lanes. Classes are served round-robin
// (IFMAP -> IPSUM -> OPSUM), lanes round-robin within each class.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : fifo_glb_arbiter_if.slave (lane requests in, GLB bus, permits,
//            broadcast read data and busy out)
// Read : IDLE(grant) -> RD_ISSUE(GLB read) -> RD_RESP(push permit + data)
// Write: IDLE(grant) -> WR_ISSUE(GLB write + pop permit)
// ---------------------------------------------------------------------------
module fifo_glb_arbiter #(
    parameter int NUM_LANE = 32,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_glb_arbiter_if.slave    bus
);
    localparam int LANE_W = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_RESP, WR_ISSUE} state_t;
    typedef enum logic [1:0] {CLS_IFMAP = 2'd0, CLS_IPSUM = 2'd1, CLS_OPSUM = 2'd2} class_t;

    // Unpacked per-lane views of the flattened matrices
    logic [NUM_LANE-1:0] req_cls [3];
    logic [ADDR_W-1:0]   ifmap_addr [NUM_LANE];
    logic [ADDR_W-1:0]   ipsum_addr [NUM_LANE];
    logic [ADDR_W-1:0]   opsum_addr [NUM_LANE];
    logic [3:0]          opsum_web  [NUM_LANE];
    logic [DATA_W-1:0]   opsum_head [NUM_LANE];

    assign req_cls[0] = bus.ifmap_read_req_matrix_i;
    assign req_cls[1] = bus.ipsum_read_req_matrix_i;
    assign req_cls[2] = bus.opsum_glb_write_req_matrix_i;

    for (genvar gi = 0; gi < NUM_LANE; gi++) begin : g_unpack
        assign ifmap_addr[gi] = bus.ifmap_glb_read_addr_matrix_i[gi*ADDR_W +: ADDR_W];
        assign ipsum_addr[gi] = bus.ipsum_glb_read_addr_matrix_i[gi*ADDR_W +: ADDR_W];
        assign opsum_addr[gi] = bus.opsum_glb_write_addr_matrix_i[gi*ADDR_W +: ADDR_W];
        assign opsum_web[gi]  = bus.opsum_glb_write_web_matrix_i[gi*4 +: 4];
        assign opsum_head[gi] = bus.opsum_fifo_head_data_matrix_i[gi*DATA_W +: DATA_W];
    end

    // State and latched transaction
    state_t             state_reg, state_next;
    class_t             class_ptr_reg, class_ptr_next;
    logic [LANE_W-1:0]  lane_ptr_reg [3];
    logic [LANE_W-1:0]  lane_ptr_next [3];
    class_t             win_class_reg, win_class_next;
    logic [LANE_W-1:0]  win_lane_reg, win_lane_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [3:0]         web_reg, web_next;
    logic [DATA_W-1:0]  wdata_reg, wdata_next;

    // Winner selection
    logic               sel_valid;
    class_t             sel_class;
    logic [LANE_W-1:0]  sel_lane;
    logic [1:0]         cand_cls;
    logic [LANE_W-1:0]  cand_lane;
    logic               lane_found;

    always_comb begin
        sel_valid  = 1'b0;
        sel_class  = CLS_IFMAP;
        sel_lane   = '0;
        lane_found = 1'b0;
        // Class search starts at the class pointer itself
        cand_cls   = class_ptr_reg;
        for (int k = 0; k < 3; k++) begin
            if (!sel_valid && (|req_cls[cand_cls])) begin
                sel_valid = 1'b1;
                sel_class = class_t'(cand_cls);
            end
            cand_cls = (cand_cls == 2'd2) ? 2'd0 : cand_cls + 2'd1;
        end
        // Lane search starts one past the lane pointer (last winner)
        cand_lane = lane_ptr_reg[sel_class];
        for (int k = 0; k < NUM_LANE; k++) begin
            cand_lane = (cand_lane == LANE_W'(NUM_LANE - 1)) ? '0 : cand_lane + 1'b1;
            if (!lane_found && req_cls[sel_class][cand_lane]) begin
                lane_found = 1'b1;
                sel_lane   = cand_lane;
            end
        end
    end

    // Outputs built from state and latched registers only
    logic               glb_en;
    logic [ADDR_W-1:0]  glb_addr;
    logic [3:0]         glb_web;
    logic [DATA_W-1:0]  glb_wdata;
    logic [DATA_W-1:0]  ifmap_rdata;
    logic [DATA_W-1:0]  ipsum_rdata;

    always_comb begin
        state_next     = state_reg;
        class_ptr_next = class_ptr_reg;
        lane_ptr_next  = lane_ptr_reg;
        win_class_next = win_class_reg;
        win_lane_next  = win_lane_reg;
        addr_next      = addr_reg;
        web_next       = web_reg;
        wdata_next     = wdata_reg;
        glb_en         = 1'b0;
        glb_addr       = '0;
        glb_web        = 4'd0;
        glb_wdata      = '0;
        ifmap_rdata    = '0;
        ipsum_rdata    = '0;
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    win_class_next           = sel_class;
                    win_lane_next            = sel_lane;
                    lane_ptr_next[sel_class] = sel_lane;
                    case (sel_class)
                        CLS_IFMAP: begin
                            addr_next      = ifmap_addr[sel_lane];
                            web_next       = 4'd0;
                            wdata_next     = '0;
                            class_ptr_next = CLS_IPSUM;
                            state_next     = RD_ISSUE;
                        end
                        CLS_IPSUM: begin
                            addr_next      = ipsum_addr[sel_lane];
                            web_next       = 4'd0;
                            wdata_next     = '0;
                            class_ptr_next = CLS_OPSUM;
                            state_next     = RD_ISSUE;
                        end
                        default: begin
                            addr_next      = opsum_addr[sel_lane];
                            web_next       = opsum_web[sel_lane];
                            wdata_next     = opsum_head[sel_lane];
                            class_ptr_next = CLS_IFMAP;
                            state_next     = WR_ISSUE;
                        end
                    endcase
                end
            end
            RD_ISSUE: begin
                glb_en     = 1'b1;
                glb_addr   = addr_reg;
                state_next = RD_RESP;
            end
            RD_RESP: begin
                // GLB data arrives this cycle; pass it straight to the lanes
                if (win_class_reg == CLS_IFMAP) ifmap_rdata = bus.glb_read_data_i;
                else                            ipsum_rdata = bus.glb_read_data_i;
                state_next = IDLE;
            end
            WR_ISSUE: begin
                glb_en     = 1'b1;
                glb_addr   = addr_reg;
                glb_web    = web_reg;
                glb_wdata  = wdata_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            class_ptr_reg <= CLS_IFMAP;
            for (int c = 0; c < 3; c++) lane_ptr_reg[c] <= LANE_W'(NUM_LANE - 1);
            win_class_reg <= CLS_IFMAP;
            win_lane_reg  <= '0;
            addr_reg      <= '0;
            web_reg       <= 4'd0;
            wdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            class_ptr_reg <= class_ptr_next;
            lane_ptr_reg  <= lane_ptr_next;
            win_class_reg <= win_class_next;
            win_lane_reg  <= win_lane_next;
            addr_reg      <= addr_next;
            web_reg       <= web_next;
            wdata_reg     <= wdata_next;
        end
    end

    // Permit pulses: decoded per lane from the latched winner
    logic               ifmap_resp, ipsum_resp, opsum_wr;
    logic [NUM_LANE-1:0] ifmap_permit, ipsum_permit, opsum_permit;

    assign ifmap_resp = (state_reg == RD_RESP) && (win_class_reg == CLS_IFMAP);
    assign ipsum_resp = (state_reg == RD_RESP) && (win_class_reg == CLS_IPSUM);
    assign opsum_wr   = (state_reg == WR_ISSUE);

    for (genvar gi = 0; gi < NUM_LANE; gi++) begin : g_permit
        assign ifmap_permit[gi] = ifmap_resp && (win_lane_reg == LANE_W'(gi));
        assign ipsum_permit[gi] = ipsum_resp && (win_lane_reg == LANE_W'(gi));
        assign opsum_permit[gi] = opsum_wr   && (win_lane_reg == LANE_W'(gi));
    end

    assign bus.glb_en_o                   = glb_en;
    assign bus.glb_addr_o                 = glb_addr;
    assign bus.glb_web_o                  = glb_web;
    assign bus.glb_wdata_o                = glb_wdata;
    assign bus.ifmap_permit_push_matrix_o = ifmap_permit;
    assign bus.ipsum_permit_push_matrix_o = ipsum_permit;
    assign bus.opsum_permit_pop_matrix_o  = opsum_permit;
    assign bus.ifmap_glb_read_data_o      = ifmap_rdata;
    assign bus.ipsum_glb_read_data_o      = ipsum_rdata;
    assign bus.fifo_glb_busy_o            = (state_reg != IDLE);
endmodule
